// File: rtl/spi_exe_unit_2.sv
// Serial SPI-slave ALU: receives opcode, A and B on MOSI in one CS frame,
// executes them and shifts the M-bit result plus {CF,OF,ZF,SF} back on MISO.
`timescale 1ns/1ps
module spi_exe_unit_2 #(
  parameter int M         = 8,
  parameter int N         = 4,
  parameter int LSB_FIRST = 0
) (
  input  logic i_sclk,
  input  logic i_rst,
  input  logic i_cs,
  input  logic i_mosi,
  output logic o_miso,
  output logic o_done,
  output logic o_err
);

  localparam int TOT = N + 2 * M;
  localparam int TXW = M + 4;
  localparam int SW  = $clog2(M);
  localparam int CW  = $clog2(TOT + TXW + 1);

  localparam logic [N-1:0] OP_ADD = N'(0);
  localparam logic [N-1:0] OP_SUB = N'(1);
  localparam logic [N-1:0] OP_AND = N'(2);
  localparam logic [N-1:0] OP_OR  = N'(3);
  localparam logic [N-1:0] OP_XOR = N'(4);
  localparam logic [N-1:0] OP_NOT = N'(5);
  localparam logic [N-1:0] OP_SHL = N'(6);
  localparam logic [N-1:0] OP_SHR = N'(7);
  localparam logic [N-1:0] OP_ASR = N'(8);

  typedef enum logic [2:0] {IDLE, RX, EXEC, TX, DONE, WAIT_HI} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [TOT-2:0]  rx_sr_reg, rx_sr_next;
  logic [N-1:0]    op_reg, op_next;
  logic [M-1:0]    a_reg, a_next;
  logic [M-1:0]    b_reg, b_next;
  logic [TXW-1:0]  tx_sr_reg, tx_sr_next;
  logic            miso_reg, miso_next;
  logic            err_reg, err_next;

  // The final MOSI bit is taken straight from the pin on the completing edge.
  logic [TOT-1:0] rx_full;
  logic [N-1:0]   op_raw, op_rx;
  logic [M-1:0]   a_raw, a_rx, b_raw, b_rx;

  assign rx_full = {rx_sr_reg, i_mosi};
  assign op_raw  = rx_full[TOT-1:2*M];
  assign a_raw   = rx_full[2*M-1:M];
  assign b_raw   = rx_full[M-1:0];

  // ALU on the registered operands
  logic [M-1:0]        alu_res;
  logic                alu_cf, alu_of;
  logic [3:0]          alu_flags;
  logic [SW-1:0]       sh_amt;
  logic [M:0]          add_w, sub_w, shl_w, shr_w;
  logic signed [M:0]   asr_w;

  assign sh_amt = b_reg[SW-1:0];
  assign add_w  = {1'b0, a_reg} + {1'b0, b_reg};
  assign sub_w  = {1'b0, a_reg} - {1'b0, b_reg};
  // Widened by one bit so the last bit shifted out lands in the spare position.
  assign shl_w  = {1'b0, a_reg} << sh_amt;
  assign shr_w  = {a_reg, 1'b0} >> sh_amt;
  assign asr_w  = $signed({a_reg, 1'b0}) >>> sh_amt;

  always_comb begin
    alu_res   = '0;
    alu_cf    = 1'b0;
    alu_of    = 1'b0;
    alu_flags = 4'b1111;
    if (op_reg <= OP_ASR) begin
      case (op_reg)
        OP_ADD: begin
          alu_res = add_w[M-1:0];
          alu_cf  = add_w[M];
          alu_of  = (a_reg[M-1] == b_reg[M-1]) && (add_w[M-1] != a_reg[M-1]);
        end
        OP_SUB: begin
          alu_res = sub_w[M-1:0];
          alu_cf  = sub_w[M];
          alu_of  = (a_reg[M-1] != b_reg[M-1]) && (sub_w[M-1] != a_reg[M-1]);
        end
        OP_AND: alu_res = a_reg & b_reg;
        OP_OR:  alu_res = a_reg | b_reg;
        OP_XOR: alu_res = a_reg ^ b_reg;
        OP_NOT: alu_res = ~a_reg;
        OP_SHL: begin
          alu_res = shl_w[M-1:0];
          alu_cf  = shl_w[M];
        end
        OP_SHR: begin
          alu_res = shr_w[M:1];
          alu_cf  = shr_w[0];
        end
        OP_ASR: begin
          alu_res = asr_w[M:1];
          alu_cf  = asr_w[0];
        end
        default: alu_res = '0;
      endcase
      alu_flags = {alu_cf, alu_of, (alu_res == '0), alu_res[M-1]};
    end
  end

  // Per-field bit reversal when fields travel LSB-first.
  logic [M-1:0] res_tx;
  logic [3:0]   flg_tx;
  logic [TXW-1:0] tx_word;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_op
      assign op_rx[gi] = (LSB_FIRST != 0) ? op_raw[N-1-gi] : op_raw[gi];
    end
    for (genvar gi = 0; gi < M; gi++) begin : g_word
      assign a_rx[gi]   = (LSB_FIRST != 0) ? a_raw[M-1-gi]   : a_raw[gi];
      assign b_rx[gi]   = (LSB_FIRST != 0) ? b_raw[M-1-gi]   : b_raw[gi];
      assign res_tx[gi] = (LSB_FIRST != 0) ? alu_res[M-1-gi] : alu_res[gi];
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_flg
      assign flg_tx[gi] = (LSB_FIRST != 0) ? alu_flags[3-gi] : alu_flags[gi];
    end
  endgenerate

  assign tx_word = {res_tx, flg_tx};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rx_sr_next = rx_sr_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    tx_sr_next = tx_sr_reg;
    miso_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!i_cs) begin
          rx_sr_next = {rx_sr_reg[TOT-3:0], i_mosi};
          cnt_next   = CW'(1);
          state_next = RX;
        end
      end
      RX: begin
        if (i_cs) begin
          state_next = IDLE;
        end else if (cnt_reg == CW'(TOT - 1)) begin
          op_next    = op_rx;
          a_next     = a_rx;
          b_next     = b_rx;
          err_next   = (op_rx > OP_ASR);
          state_next = EXEC;
        end else begin
          rx_sr_next = {rx_sr_reg[TOT-3:0], i_mosi};
          cnt_next   = cnt_reg + CW'(1);
        end
      end
      EXEC: begin
        if (i_cs) begin
          state_next = IDLE;
        end else begin
          tx_sr_next = tx_word;
          miso_next  = tx_word[TXW-1];
          cnt_next   = CW'(1);
          state_next = TX;
        end
      end
      TX: begin
        if (i_cs) begin
          state_next = IDLE;
        end else if (cnt_reg == CW'(TXW)) begin
          state_next = DONE;
        end else begin
          miso_next  = tx_sr_reg[TXW-2];
          tx_sr_next = tx_sr_reg << 1;
          cnt_next   = cnt_reg + CW'(1);
        end
      end
      DONE:    state_next = WAIT_HI;
      WAIT_HI: if (i_cs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rx_sr_reg <= '0;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      tx_sr_reg <= '0;
      miso_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rx_sr_reg <= rx_sr_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      tx_sr_reg <= tx_sr_next;
      miso_reg  <= miso_next;
      err_reg   <= err_next;
    end
  end

  assign o_miso = miso_reg;
  assign o_err  = err_reg;
  assign o_done = (state_reg == DONE);

endmodule

// File: doc/spi_exe_unit_2.md
Name: spi_exe_unit_2

Overview:
- Parametrised successor to the first-generation SPI execution unit.
- A serial SPI-slave ALU. It receives an opcode and two M-bit operands on MOSI within one chip-select frame, then executes them with an internal ALU.
- It shifts the result and 4 flags back on MISO, selectable bit order in both directions.
- Added over the previous generation: generic widths, frame abort on early CS release, invalid-opcode error reporting, done strobe, and guarded back-to-back frames.

Parameters:
- M, 8, operand/result width in bits (M ≥ 4, power of 2).
- N, 4, opcode width in bits (N ≥ 4).
- LSB_FIRST, 0, 0 = every field MSB-first on MOSI and MISO; 1 = every field LSB-first.

Ports:
- i_sclk  in  1  serial clock; all logic on rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_cs  in  1  chip select, active-low, sampled on i_sclk rising edge.
- i_mosi  in  1  serial data in, sampled on rising edge.
- o_miso  out  1  serial data out, registered.
- o_done  out  1  one-cycle pulse at frame completion.
- o_err  out  1  one-cycle pulse in EXEC when the opcode is invalid.

Behaviour:
- Interface: one clock, i_sclk. Reset i_rst is asynchronous and active-high.
- Reset (any time, including mid-frame):
  - state = IDLE;
  - bit counter, opcode, A, B and output shift registers = 0;
  - o_miso = 0, o_done = 0, o_err = 0.
- States: IDLE, RX, EXEC, TX, DONE, WAIT_HI.
- IDLE:
  - o_miso = 0.
  - At an edge with i_cs = 0: this edge samples the first opcode bit; counter = 1; go to RX.
- RX:
  - Each edge shifts i_mosi into a receive register.
  - Total bits = N+2M, order opcode, A, B. In the default config: 4 + 8 + 8 = 20 edges including the IDLE edge.
  - The edge that samples the last B bit moves to EXEC.
- EXEC (1 cycle):
  - ALU is combinational on the registered opcode/A/B.
  - At the EXEC edge, load TX register with {result[M-1:0], CF, OF, ZF, SF}; o_miso = first bit.
  - Go to TX.
- TX:
  - Each edge presents the next bit on o_miso.
  - Each of the M+4 bits is held exactly one cycle; the first bit is driven from the EXEC edge.
  - After the last bit's cycle, go to DONE. o_miso returns to 0.
- DONE: o_done = 1 for one cycle; go to WAIT_HI.
- WAIT_HI: stay until i_cs is sampled 1, then IDLE. No new frame starts without a CS high phase.
- Abort: i_cs = 1 sampled in RX, EXEC or TX → IDLE next edge.
  - o_miso = 0; no o_done; no o_err.
  - Partial data discarded; registers are not updated by that frame.
- LSB_FIRST = 1 reverses bit order within each field (opcode, A, B, result, flag nibble). The field order is unchanged.
- ALU, unsigned operands, result mod 2^M. CF/OF are 0 unless stated.
  - 0 ADD A+B: CF = carry out; OF = signed overflow.
  - 1 SUB A−B: CF = borrow (A < B unsigned); OF = signed overflow.
  - 2 AND; 3 OR; 4 XOR.
  - 5 NOT A.
  - 6 SHL A by B[log2 M−1:0]: CF = last bit shifted out; 0 if amount is 0.
  - 7 SHR logical: CF as SHL.
  - 8 ASR: CF as SHL.
  - 9..2^N−1 invalid: result 0, flags 4'b1111, o_err pulse during EXEC.
- SF = result[M−1]; ZF = (result == 0). Both apply to every valid opcode.
- Simultaneous events: i_rst overrides everything. In IDLE or WAIT_HI with i_cs = 1 nothing happens.

Test Plan:
- Reset → o_miso = 0, o_done = 0, o_err = 0. Assert i_rst mid-RX → IDLE immediately; next full frame is correct.
- ADD, opcode 0x0, A = 0x7F, B = 0x01 → MISO 12 bits 1000_0000_0101 (0x80, CF0 OF1 ZF0 SF1). o_done pulses 1 cycle after the last bit.
- SUB, opcode 0x1, A = 0x10, B = 0x20 → 0xF0, flags 1001. SHL, opcode 0x6, A = 0x81, B = 0x01 → 0x02, flags 1000. ADD 0x00 + 0x00 → ZF only (0010).
- Opcode 0xF, any A/B → o_err pulse in EXEC; MISO 0000_0000_1111; o_done still pulses.
- Abort: i_cs rises after 6 RX bits → no o_done, o_miso stays 0. Next frame, ADD 0x01 + 0x02, returns 0x03, flags 0000.
- Two cases:
  - i_cs held low past DONE → no second frame.
  - i_cs pulsed high one cycle, then a second frame → both results correct.
  - Repeat the ADD case with LSB_FIRST = 1 and bit-reversed fields.
